// File: rtl/d_cache_pkg.sv
// Shared dcache definitions: op codes, load size codes, align-stage state
// encoding and the latched load-request payload.
package d_cache_pkg;

    // Operation codes carried alongside requests.
    localparam logic [2:0] NOOP  = 3'd0;
    localparam logic [2:0] LD    = 3'd1;
    localparam logic [2:0] ST    = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] WR    = 3'd4;
    localparam logic [2:0] INV   = 3'd5;
    localparam logic [2:0] UPD   = 3'd6;
    localparam logic [2:0] WR_LD = 3'd7;

    // Access size codes.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUT     = 2'd2
    } align_state_e;

    // Request fields held for the whole life of a load.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [2:0]  op;
    } ld_req_t;

    // Number of bytes touched by a size code (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'(1) << size;
    endfunction

endpackage

// File: rtl/d_load_align_if.sv
// Bus bundle of the load align stage.
//   request : req_valid/req_ready, req_addr, req_size, req_sext, req_op, req_tag
//   banks   : e_valid/e_data (even line), o_valid/o_data (odd line), flush
//   result  : out_valid/out_ready, out_data, out_addr, out_op, out_tag, out_err
//   status  : busy
// slave = align stage side, master = requester/bank/consumer side.
interface d_load_align_if #(
    parameter int unsigned CL_SIZE      = 128,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned OOO_TAG_SIZE = 10
);
    logic                    req_valid;
    logic                    req_ready;
    logic [31:0]             req_addr;
    logic [1:0]              req_size;
    logic                    req_sext;
    logic [2:0]              req_op;
    logic [OOO_TAG_SIZE-1:0] req_tag;

    logic                    e_valid;
    logic [CL_SIZE-1:0]      e_data;
    logic                    o_valid;
    logic [CL_SIZE-1:0]      o_data;
    logic                    flush;

    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_data;
    logic [31:0]             out_addr;
    logic [2:0]              out_op;
    logic [OOO_TAG_SIZE-1:0] out_tag;
    logic                    out_err;
    logic                    busy;

    modport slave (
        input  req_valid, req_addr, req_size, req_sext, req_op, req_tag,
        input  e_valid, e_data, o_valid, o_data, flush, out_ready,
        output req_ready, out_valid, out_data, out_addr, out_op, out_tag,
        output out_err, busy
    );

    modport master (
        output req_valid, req_addr, req_size, req_sext, req_op, req_tag,
        output e_valid, e_data, o_valid, o_data, flush, out_ready,
        input  req_ready, out_valid, out_data, out_addr, out_op, out_tag,
        input  out_err, busy
    );
endinterface

// File: rtl/d_align_ext.sv
// Combinational shift/select/extend of a two-line window.
//   i_full   : {hi_line, lo_line}, lo_line holds the first byte
//   i_off    : byte offset of the first byte within lo_line
//   i_size   : size code (byte/half/word/double)
//   i_sext   : 1 = sign-extend, 0 = zero-extend
//   o_data_c : aligned, extended result (XLEN bits)
module d_align_ext
    import d_cache_pkg::*;
#(
    parameter int unsigned CL_SIZE = 128,
    parameter int unsigned XLEN    = 32
) (
    input  logic [2*CL_SIZE-1:0]          i_full,
    input  logic [$clog2(CL_SIZE/8)-1:0]  i_off,
    input  logic [1:0]                    i_size,
    input  logic                          i_sext,
    output logic [XLEN-1:0]               o_data_c
);

    logic [63:0] w_raw;
    logic [63:0] w_ext;

    // Only the low doubleword of the shifted window can ever be selected.
    assign w_raw = 64'(i_full >> {i_off, 3'b000});

    always_comb begin
        w_ext = w_raw;
        unique case (i_size)
            SZ_B:    w_ext = {{56{i_sext & w_raw[7]}},  w_raw[7:0]};
            SZ_H:    w_ext = {{48{i_sext & w_raw[15]}}, w_raw[15:0]};
            SZ_W:    w_ext = {{32{i_sext & w_raw[31]}}, w_raw[31:0]};
            default: w_ext = w_raw;
        endcase
    end

    assign o_data_c = XLEN'(w_ext);

endmodule

// File: rtl/d_load_align.sv
// Load-return merge/align stage between the even/odd dcache banks and the
// load writeback path. Accepts one load, collects the home line (and the
// next, opposite-parity line for line-crossing loads), aligns and extends
// the data and holds it under a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : d_load_align_if.slave (request, bank returns, flush, result)
// Build option D_LOAD_ALIGN_SPLIT_EN: when defined, line-crossing loads are
// collected from both banks; when undefined they complete at once with
// out_err=1 and no hi-line storage exists.
module d_load_align
    import d_cache_pkg::*;
#(
    parameter int unsigned CL_SIZE      = 128,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned OOO_TAG_SIZE = 10
) (
    input  logic           clk,
    input  logic           rst,
    d_load_align_if.slave  bus
);

    localparam int unsigned OFF = $clog2(CL_SIZE / 8);

    align_state_e            r_state;
    align_state_e            w_state_nxt;
    ld_req_t                 r_req;
    logic [1:0]              r_need;      // [0] even bank, [1] odd bank
    logic [1:0]              r_have;
    logic [CL_SIZE-1:0]      r_lo_line;
    logic                    r_req_ready;
    logic                    r_busy;
    logic                    r_out_valid;
    logic                    r_out_err;
    logic [XLEN-1:0]         r_out_data;
    logic [OOO_TAG_SIZE-1:0] r_out_tag;

    // Incoming request decode.
    logic [OFF-1:0] w_off;
    logic           w_par;
    logic [3:0]     w_nbytes;
    logic           w_need_p1;
    logic           w_illegal;
    logic [1:0]     w_need;
    logic           w_accept;

    assign w_off     = bus.req_addr[OFF-1:0];
    assign w_par     = bus.req_addr[OFF];
    assign w_nbytes  = size_bytes(bus.req_size);
    // Crosses into the next line when off + nbytes exceeds the line size.
    assign w_need_p1 = ({1'b0, w_off} + (OFF+1)'(w_nbytes)) > {1'b1, {OFF{1'b0}}};
    assign w_need    = w_par ? {1'b1, w_need_p1} : {w_need_p1, 1'b1};
`ifdef D_LOAD_ALIGN_SPLIT_EN
    assign w_illegal = (bus.req_size == SZ_D) && (XLEN == 32);
`else
    assign w_illegal = ((bus.req_size == SZ_D) && (XLEN == 32)) || w_need_p1;
`endif
    // A flush in IDLE blocks a coincident request.
    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid && !bus.flush;

    // Bank capture: first valid for each still-missing needed bank wins.
    logic               w_take_e;
    logic               w_take_o;
    logic [1:0]         w_have_nxt;
    logic               w_done;
    logic               w_r_par;
    logic               w_lo_take;
    logic [CL_SIZE-1:0] w_lo_in;
    logic [CL_SIZE-1:0] w_lo_eff;
    logic [CL_SIZE-1:0] w_hi_eff;
    logic [XLEN-1:0]    w_aligned;

    assign w_take_e   = bus.e_valid && r_need[0] && !r_have[0];
    assign w_take_o   = bus.o_valid && r_need[1] && !r_have[1];
    assign w_have_nxt = r_have | {w_take_o, w_take_e};
    assign w_done     = (w_have_nxt == r_need);
    assign w_r_par    = r_req.addr[OFF];
    assign w_lo_take  = w_r_par ? w_take_o : w_take_e;
    assign w_lo_in    = w_r_par ? bus.o_data : bus.e_data;
    // Bypass so a half captured this cycle feeds the result directly.
    assign w_lo_eff   = w_lo_take ? w_lo_in : r_lo_line;

`ifdef D_LOAD_ALIGN_SPLIT_EN
    logic [CL_SIZE-1:0] r_hi_line;
    logic               w_hi_take;
    logic [CL_SIZE-1:0] w_hi_in;

    assign w_hi_take = w_r_par ? w_take_e : w_take_o;
    assign w_hi_in   = w_r_par ? bus.e_data : bus.o_data;
    assign w_hi_eff  = w_hi_take ? w_hi_in : r_hi_line;
`else
    assign w_hi_eff  = '0;
`endif

    d_align_ext #(
        .CL_SIZE (CL_SIZE),
        .XLEN    (XLEN)
    ) u_align (
        .i_full   ({w_hi_eff, w_lo_eff}),
        .i_off    (r_req.addr[OFF-1:0]),
        .i_size   (r_req.size),
        .i_sext   (r_req.sext),
        .o_data_c (w_aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? ST_OUT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.flush || bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state enables for the capture and result registers.
    logic w_collect;
    logic w_cap_lo;
    logic w_cap_hi;
    logic w_result;

    always_comb begin
        w_collect = 1'b0;
        w_cap_lo  = 1'b0;
        w_cap_hi  = 1'b0;
        w_result  = 1'b0;
        if ((r_state == ST_COLLECT) && !bus.flush) begin
            w_collect = 1'b1;
            w_cap_lo  = w_lo_take;
`ifdef D_LOAD_ALIGN_SPLIT_EN
            w_cap_hi  = w_hi_take;
`endif
            w_result  = w_done;
        end
    end

    // Control, request and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= '0;
            r_need      <= '0;
            r_have      <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_OUT);
            if (w_accept) begin
                r_req      <= '{addr: bus.req_addr, size: bus.req_size,
                                sext: bus.req_sext, op: bus.req_op};
                r_out_tag  <= bus.req_tag;
                r_need     <= w_need;
                r_have     <= '0;
                r_out_err  <= w_illegal;
                r_out_data <= '0;
            end else if (w_collect) begin
                r_have <= w_have_nxt;
                if (w_result) begin
                    r_out_data <= w_aligned;
                    r_out_err  <= 1'b0;
                end
            end else if (r_state == ST_COLLECT) begin
                r_have <= '0;
            end
        end
    end

    // Line storage; validity is tracked by r_have, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_cap_lo) begin
            r_lo_line <= w_lo_in;
        end
    end

`ifdef D_LOAD_ALIGN_SPLIT_EN
    always_ff @(posedge clk) begin
        if (w_cap_hi) begin
            r_hi_line <= w_hi_in;
        end
    end
`else
    logic w_unused_cap_hi;
    assign w_unused_cap_hi = w_cap_hi;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_err   = r_out_err;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_req.addr;
    assign bus.out_op    = r_req.op;
    assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_d_load_align.sv
// Bench for d_load_align: directed cases plus randomized loads checked
// against a byte-array reference model of the load result.
module tb_d_load_align;
    import d_cache_pkg::*;

    localparam int unsigned CL_SIZE = 128;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TAGW    = 10;
    localparam int unsigned LB      = CL_SIZE / 8;
`ifdef D_LOAD_ALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    d_load_align_if #(.CL_SIZE(CL_SIZE), .XLEN(XLEN), .OOO_TAG_SIZE(TAGW)) bus ();

    d_load_align #(.CL_SIZE(CL_SIZE), .XLEN(XLEN), .OOO_TAG_SIZE(TAGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [CL_SIZE-1:0] rnd_line();
        logic [CL_SIZE-1:0] l;
        for (int i = 0; i < int'(CL_SIZE / 32); i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference: pick nb bytes from the two-line byte stream starting at off.
    function automatic logic [63:0] model_data(input logic [CL_SIZE-1:0] lo,
                                               input logic [CL_SIZE-1:0] hi,
                                               input int off, input int nb,
                                               input bit sext);
        logic [7:0]  b [2*LB];
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < int'(LB); i++) begin
            b[i]      = lo[i*8 +: 8];
            b[i + LB] = hi[i*8 +: 8];
        end
        for (int j = 0; j < nb; j++) v = v | (64'(b[off + j]) << (8 * j));
        if (sext && nb < 8 && v[8*nb-1]) v = v | (~64'(0) << (8 * nb));
        if (XLEN < 64) v = v & ~(~64'(0) << XLEN);
        return v;
    endfunction

    // One full load: request, bank returns at given cycles, hold, handshake.
    task automatic run_load(input logic [31:0] addr, input logic [1:0] size,
                            input bit sext, input logic [CL_SIZE-1:0] el,
                            input logic [CL_SIZE-1:0] ol, input int e_dly,
                            input int o_dly, input int hold,
                            output logic [63:0] got);
        int off, nb, first, exp_cyc, last;
        bit par, need_p1, illegal, need_e, need_o;
        logic [63:0] exp_d;
        logic [CL_SIZE-1:0] lo, hi;
        logic [TAGW-1:0] tag;
        logic [2:0] op;

        off     = int'(addr % LB);
        par     = ((addr / LB) % 2) == 1;
        nb      = 1 << size;
        need_p1 = (off + nb) > int'(LB);
        illegal = (size == 2'd3 && XLEN == 32) || (need_p1 && !SPLIT);
        lo      = par ? ol : el;
        hi      = par ? el : ol;
        exp_d   = illegal ? 64'h0 : model_data(lo, hi, off, nb, sext);
        need_e  = !par || need_p1;
        need_o  = par || need_p1;
        last    = 0;
        if (need_e && e_dly > last) last = e_dly;
        if (need_o && o_dly > last) last = o_dly;
        exp_cyc = illegal ? 1 : last + 1;
        tag     = TAGW'($urandom);
        op      = 3'($urandom);

        chk("idle_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_op    = op;
        bus.req_tag   = tag;
        // Bank valids in the accept cycle must be ignored.
        bus.e_valid   = rbit();
        bus.e_data    = rnd_line();
        bus.o_valid   = rbit();
        bus.o_data    = rnd_line();
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_size  = 2'($urandom);
        bus.req_sext  = rbit();
        bus.req_op    = 3'($urandom);
        bus.req_tag   = TAGW'($urandom);

        first = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.out_valid) begin
                first = k;
                break;
            end
            bus.e_valid = need_e ? ((k == e_dly) || (k > e_dly && rbit())) : rbit();
            bus.e_data  = (need_e && k == e_dly) ? el : rnd_line();
            bus.o_valid = need_o ? ((k == o_dly) || (k > o_dly && rbit())) : rbit();
            bus.o_data  = (need_o && k == o_dly) ? ol : rnd_line();
            step();
        end
        bus.e_valid = 1'b0;
        bus.o_valid = 1'b0;

        chk("latency", 64'(first), 64'(exp_cyc));
        chk("data", 64'(bus.out_data), exp_d);
        chk("err", 64'(bus.out_err), 64'(illegal));
        chk("tag", 64'(bus.out_tag), 64'(tag));
        chk("op", 64'(bus.out_op), 64'(op));
        chk("addr", 64'(bus.out_addr), 64'(addr));
        chk("out_req_ready", 64'(bus.req_ready), 64'd0);
        chk("out_busy", 64'(bus.busy), 64'd1);
        got = 64'(bus.out_data);

        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.e_valid   = rbit();
            bus.e_data    = rnd_line();
            bus.o_valid   = rbit();
            bus.o_data    = rnd_line();
            step();
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(bus.out_data), exp_d);
            chk("hold_tag", 64'(bus.out_tag), 64'(tag));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.e_valid   = 1'b0;
        bus.o_valid   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("done_valid", 64'(bus.out_valid), 64'd0);
        chk("done_req_ready", 64'(bus.req_ready), 64'd1);
        chk("done_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [1:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_sext  = 1'b0;
        bus.req_op    = LD;
        bus.req_tag   = TAGW'($urandom);
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [CL_SIZE-1:0] el, ol;
        logic [63:0] got;
        logic [31:0] a;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_sext  = 1'b0;
        bus.req_op    = '0;
        bus.req_tag   = '0;
        bus.e_valid   = 1'b0;
        bus.e_data    = '0;
        bus.o_valid   = 1'b0;
        bus.o_data    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_out_op", 64'(bus.out_op), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

        // Word load, bytes k=k.
        for (int i = 0; i < int'(LB); i++) el[i*8 +: 8] = 8'(i);
        run_load(32'h1004, SZ_W, 1'b0, el, rnd_line(), 1, 1, 0, got);
        chk("lw_const", got, 64'h07060504);

        // Byte at line end, sign- and zero-extended.
        el = rnd_line();
        el[15*8 +: 8] = 8'h80;
        run_load(32'h100F, SZ_B, 1'b1, el, rnd_line(), 2, 1, 1, got);
        chk("lb_sext_const", got, 64'hFFFFFF80);
        run_load(32'h100F, SZ_B, 1'b0, el, rnd_line(), 1, 3, 0, got);
        chk("lb_zext_const", got, 64'h00000080);

        // Split word across odd (home) and even lines, halves 3 cycles apart.
        el = rnd_line();
        ol = rnd_line();
        ol[14*8 +: 8] = 8'h11;
        ol[15*8 +: 8] = 8'h22;
        el[0 +: 8]    = 8'h33;
        el[8 +: 8]    = 8'h44;
        run_load(32'h101E, SZ_W, 1'b0, el, ol, 1, 4, 3, got);
        chk("split_const", got, SPLIT ? 64'h44332211 : 64'h0);

        // Doubleword load (illegal at XLEN=32).
        run_load(32'h1000, SZ_D, 1'b1, rnd_line(), rnd_line(), 1, 1, 0, got);

        // Randomized loads, biased toward line ends.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if (rbit()) a = (a & ~32'(LB - 1)) | 32'(LB - 1 - $urandom_range(0, 3));
            run_load(a, 2'($urandom), rbit(), rnd_line(), rnd_line(),
                     int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                     int'($urandom_range(0, 3)), got);
        end

        // Flush in COLLECT; same-cycle and later bank valids are discarded.
        send_req(32'h2000, SZ_W);
        bus.flush   = 1'b1;
        bus.e_valid = 1'b1;
        bus.o_valid = 1'b1;
        step();
        bus.flush   = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_req_ready", 64'(bus.req_ready), 64'd1);
        step();
        bus.e_valid = 1'b0;
        bus.o_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("flush_no_valid", 64'(bus.out_valid), 64'd0);
            step();
        end
        chk("flush_idle", 64'(bus.busy), 64'd0);

        // Flush in IDLE blocks a coincident request.
        bus.flush = 1'b1;
        send_req(32'h2100, SZ_B);
        bus.flush = 1'b0;
        chk("flush_idle_busy", 64'(bus.busy), 64'd0);
        chk("flush_idle_ready", 64'(bus.req_ready), 64'd1);
        step();
        chk("flush_idle_busy2", 64'(bus.busy), 64'd0);

        // Flush in OUT with out_ready low drops the result.
        send_req(32'h4000, SZ_W);
        bus.e_valid = 1'b1;
        bus.e_data  = rnd_line();
        step();
        bus.e_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_out_drop", 64'(bus.out_valid), 64'd0);
        chk("flush_out_ready", 64'(bus.req_ready), 64'd1);

        // Reset mid-collect discards everything.
        send_req(32'h3004, SZ_H);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_tag", 64'(bus.out_tag), 64'd0);
        chk("midrst_addr", 64'(bus.out_addr), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd1);
        bus.e_valid = 1'b1;
        step();
        bus.e_valid = 1'b0;
        chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
        run_load(32'h3006, SZ_H, 1'b1, rnd_line(), rnd_line(), 2, 2, 1, got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/d_load_align.md
Name: d_load_align

Overview:
- Load-return merge/align stage between the even/odd dcache banks and the load writeback path.
- Accepts one load request and collects the line(s) it needs from the even and odd banks. Halves may arrive in different cycles.
- Shifts the bytes into place, zero- or sign-extends to XLEN, and holds the result in an output register under a valid/ready handshake.
- Compared with the prior merge stage it adds XLEN width generalisation, doubleword loads, split-line collection across cycles, backpressure and flush.

Parameters:
- CL_SIZE, 128: cache line width in bits; power of two, at least 64.
- XLEN, 32: result width in bits; legal values 32 or 64.
- OOO_TAG_SIZE, 10: width of the out-of-order tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  32  byte address of the load.
- req_size  in  2  size code: 0 byte, 1 half, 2 word, 3 double.
- req_sext  in  1  1 = sign-extend the result, 0 = zero-extend.
- req_op  in  3  operation code, passed through to the output.
- req_tag  in  OOO_TAG_SIZE  out-of-order tag, passed through to the output.
- e_valid  in  1  even-bank line valid (hit) this cycle.
- e_data  in  CL_SIZE  even-bank line data.
- o_valid  in  1  odd-bank line valid (hit) this cycle.
- o_data  in  CL_SIZE  odd-bank line data.
- flush  in  1  abort the in-flight load.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  XLEN  aligned, extended load data.
- out_addr  out  32  registered req_addr.
- out_op  out  3  registered req_op.
- out_tag  out  OOO_TAG_SIZE  registered req_tag.
- out_err  out  1  illegal request: size 3 with XLEN=32, or an unsupported split.
- busy  out  1  state is not IDLE.

Behaviour:
- Address fields:
  - OFF = log2(CL_SIZE/8).
  - off = req_addr[OFF-1:0]; nbytes = 1 << req_size.
  - Line parity = req_addr[OFF]: 0 selects the even bank, 1 the odd bank.
- need_p1 = (off + nbytes > CL_SIZE/8). The second line is the opposite-parity bank.
- Both the home bank and, when need_p1=1, the p1 bank are required.
- State machine, states IDLE, COLLECT, OUT:
  - IDLE: req_valid & req_ready latches addr, size, sext, op, tag and the needed-bank mask, then moves to COLLECT. An illegal request goes straight to OUT with out_err=1.
  - COLLECT: each needed bank's data is latched on the first cycle its valid is high. Later duplicates are ignored, and valids for unneeded banks are ignored. Once every needed half is held, the state moves to OUT. A response is never taken in the cycle the request is accepted.
  - OUT: out_valid=1 and all outputs stay stable until out_ready. On out_valid & out_ready the state returns to IDLE. The next request can be accepted in the following cycle, not in the same cycle.
- Latency: out_valid rises in the cycle after the last needed half is captured. Halves captured in the same cycle count as one arrival.
- Data path:
  - full = {hi_line, lo_line}, where lo_line is the line holding req_addr.
  - shifted = full >> (off*8); take the low nbytes*8 bits.
  - Extend to XLEN: sign-extend from bit nbytes*8-1 when sext=1, otherwise zero-extend.
  - For a double load with XLEN=64 the extension is a no-op.
- out_err=1 forces out_data=0. Tag, op and addr still pass through.
- flush:
  - In COLLECT: return to IDLE and drop captured data. Bank valids in the same cycle are discarded.
  - In OUT with out_ready low: the result is dropped.
  - In IDLE: a coincident request is not accepted.
- Reset: state IDLE; out_valid, out_data, out_err, out_addr, out_op, out_tag and busy are all 0; capture flags are cleared; req_ready=1. Reset mid-operation discards everything.

Optional Feature:
- Macro: D_LOAD_ALIGN_SPLIT_EN.
- Defined: line-crossing loads are collected as described above.
- Undefined: a request with need_p1=1 skips COLLECT and completes in OUT the cycle after acceptance, with out_err=1 and out_data=0. The hi-line capture register is not built.

Decomposition:
- Shared package d_cache_pkg holds:
  - op localparams NOOP=0, LD=1, ST=2, RD=3, WR=4, INV=5, UPD=6, WR_LD=7;
  - size codes SZ_B/SZ_H/SZ_W/SZ_D;
  - the align-state encoding.
- One combinational sub-module, d_align_ext (shift, select, extend), parametrised by CL_SIZE and XLEN. It is reusable by the store path.

Test Plan:
- Word load: CL_SIZE=128, XLEN=32; LW at 0x1004, e_data bytes k=k, e_valid on cycle 2 -> out_valid on cycle 3 with out_data=0x07060504, out_err=0.
- Byte extend: LB at 0x100F with e_data byte15=0x80 -> sext=1 gives out_data=0xFFFFFF80; sext=0 gives 0x00000080.
- Split word (SPLIT_EN): LW at 0x101E, o_data bytes14,15 = 0x11,0x22, e_data bytes0,1 = 0x33,0x44; e_valid on cycle 2, o_valid on cycle 5 -> out_valid on cycle 6, out_data=0x44332211.
- Backpressure: hold out_ready=0 for 3 cycles in OUT -> outputs stable, req_ready=0; a new request is accepted in the cycle after the handshake.
- Flush: assert flush in COLLECT, then e_valid a cycle later -> no out_valid, state IDLE, req_ready=1.
- SPLIT_EN undefined: LW at 0x101E -> out_valid the cycle after acceptance, out_err=1, out_data=0; XLEN=32 LD (size 3) -> out_err=1.
